// File: rtl/comp_seq.sv
// comp_seq: tracks max (with index) and min over COUNT accepted samples per run.
// Optional min tracking is built when COMP_SEQ_MIN_EN is defined; otherwise min_out is 0.
module comp_seq #(
    parameter int WIDTH = 2,
    parameter int COUNT = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] max_out,
    output logic [IDXW-1:0]  max_idx,
    output logic [WIDTH-1:0] min_out,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [IDXW-1:0] LAST = IDXW'(COUNT - 1);
    state_t state, state_d;
    logic [IDXW-1:0] cnt;
    logic acc, first, gt;
    always_comb begin
        acc     = state == RUN && din_valid && !clr;
        first   = cnt == '0;
        gt      = din > max_out;
        state_d = state == IDLE ? ((start && !clr) ? RUN : IDLE) :
                  state == RUN  ? (clr ? IDLE : (acc && cnt == LAST) ? DONE : RUN) :
                  IDLE;
    end
    assign din_ready = state == RUN;
    assign done      = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            max_out <= '0;
            max_idx <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE)
                cnt <= '0;
            else if (acc)
                cnt <= cnt + 1'b1;
            if (acc && (first || gt)) begin
                max_out <= din;
                max_idx <= cnt;
            end
        end
    end
`ifdef COMP_SEQ_MIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            min_out <= '0;
        else if (acc && (first || din < min_out))
            min_out <= din;
    end
`else
    assign min_out = '0;
`endif
endmodule

// File: doc/comp_seq.md
COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the bit width of each compared value.
REQ-002 The block SHALL have parameter COUNT, default 4, giving the number of samples per compare run, legal range 2..2**IDXW.
REQ-003 The block SHALL have parameter IDXW, default 2, giving the width of the sample-index output.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle request to begin a run.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous abort of a run in progress.
REQ-008 The block SHALL have port din, input, WIDTH bits: sample value.
REQ-009 The block SHALL have port din_valid, input, 1 bit: din carries a sample this cycle.
REQ-010 The block SHALL have port din_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-011 The block SHALL have port max_out, output, WIDTH bits: largest sample of the last run.
REQ-012 The block SHALL have port max_idx, output, IDXW bits: position (0-based) of max_out within its run.
REQ-013 The block SHALL have port min_out, output, WIDTH bits: smallest sample of the last run.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse on run completion.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE, encoded in a registered state variable.
REQ-016 In IDLE, din_ready SHALL be 0, and start=1 SHALL move the block to RUN with the beat counter cleared to 0.
REQ-017 In RUN, din_ready SHALL be 1, and a beat SHALL be accepted only in a cycle where din_valid=1 and din_ready=1.
REQ-018 Cycles with din_valid=0 in RUN SHALL change neither the counter nor the results.
REQ-019 The first accepted beat of a run SHALL load max_out=din, min_out=din and max_idx=0 unconditionally.
REQ-020 On each later beat, the block SHALL compare din against the stored values using unsigned WIDTH-bit magnitude with greater/equal/less flags.
REQ-021 If din>max_out, the block SHALL set max_out=din and max_idx=counter.
REQ-022 If din<min_out, the block SHALL set min_out=din.
REQ-023 On equality the stored values SHALL be kept, so the earliest index wins a tie.
REQ-024 The counter SHALL increment on each accepted beat, and accepting beat number COUNT-1 SHALL move the block to DONE on the same clock edge.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, din_ready SHALL be 0, and the next state SHALL be IDLE.
REQ-026 Results SHALL hold stable from DONE until the first accepted beat of the next run.
REQ-027 start SHALL be ignored in RUN and in DONE.
REQ-028 If start and clr are both 1 in IDLE, clr SHALL win and the block SHALL stay in IDLE.
REQ-029 clr=1 in RUN SHALL return the block to IDLE next cycle with no done pulse, and results SHALL keep their values at abort.
REQ-030 All outputs SHALL be registered or decoded from registered state only, with no combinational path from din to any output.

Reset
REQ-031 While rst_n=0, the block SHALL force state=IDLE, counter=0, max_out=0, max_idx=0, min_out=0, done=0 and din_ready=0, regardless of clk.
REQ-032 Reset asserted mid-RUN SHALL discard the run entirely, with no done pulse after release.
REQ-033 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-034 With macro COMP_SEQ_MIN_EN defined, min tracking SHALL be built per REQ-019, REQ-022, REQ-029 and REQ-031.
REQ-035 With COMP_SEQ_MIN_EN undefined, the min register and its comparator SHALL be omitted, min_out SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-036 With WIDTH=2, COUNT=4, macro defined: start, then beats 1,3,0,2 back-to-back -> done one cycle after 4th beat, max_out=3, max_idx=1, min_out=0.
REQ-037 Beats 2,2,2,2 -> max_out=2, max_idx=0, min_out=2 (tie rule).
REQ-038 Beats 0,(gap 3 cycles),3,(gap 1),3,1 -> gaps ignored, done after 4th valid beat, max_out=3, max_idx=1, min_out=0.
REQ-039 rst_n pulsed low after 2 beats -> all outputs 0 immediately, no done; a following full run of 3,2,1,0 -> max_out=3, max_idx=0, min_out=0.
REQ-040 Completed run of 1,3,0,2, then new run of 2,1 and clr -> IDLE, no done, max_out=2, max_idx=0, min_out=1 held.
REQ-041 Macro undefined, run 1,3,0,2 -> max_out=3, max_idx=1, min_out=0 throughout.
